lc3_loader: RTL and testbench

LC3_LOADER -- requirements
Module: lc3_loader

---
 rtl/lc3_loader.sv | 196 +++++++++++++++++++
 tb/tb_lc3_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_loader.sv
// ---------------------------------------------------------------------------
// lc3_loader
//
// Receives an LC-3 load image over a byte-wide valid/ready stream and writes
// its payload into memory through the MAR/MDR special-input path while the
// processor is held off.
//
// Image layout (each word sent high byte first):
//   ORIGIN, COUNT, COUNT payload words, CHECK (XOR of all payload words)
//
// Ports
//   clk         system clock, rising-edge active
//   reset       asynchronous active-low reset
//   rx_valid    an image byte is offered on rx_data
//   rx_data     image byte
//   rx_ready    loader accepts the byte this cycle
//   MARSpcIn    memory write address
//   MDRSpcIn    memory write data
//   ldMARSpcIn  one-cycle memory write strobe
//   cpu_hold    processor held off (low only after a successful load)
//   done        image loaded and checksum matched
//   error       load aborted (count too large or checksum mismatch)
// ---------------------------------------------------------------------------
module lc3_loader #(
    parameter logic [15:0] MAX_WORDS = 16'hFE00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic [15:0] MARSpcIn,
    output logic [15:0] MDRSpcIn,
    output logic        ldMARSpcIn,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_ORIGIN = 3'd0,
        S_COUNT  = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    // phase_reg = 0: next byte is a high byte; 1: next byte completes a word
    logic        phase_reg;
    logic [7:0]  hi_reg;
    logic [15:0] addr_reg;
    logic [15:0] data_reg;
    logic [15:0] remaining_reg;
    logic [15:0] acc_reg;
    logic [15:0] mar_reg;
    logic [15:0] mdr_reg;

    logic        accept;
    logic        word_done;
    logic [15:0] word;

    assign accept    = rx_valid && rx_ready;
    assign word_done = accept && phase_reg;
    assign word      = {hi_reg, rx_data};

    assign MARSpcIn  = mar_reg;
    assign MDRSpcIn  = mdr_reg;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_ORIGIN;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_ORIGIN: begin
                if (word_done) begin
                    state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (word_done) begin
                    if (word > MAX_WORDS) begin
                        state_next = S_ERR;
                    end else if (word == 16'd0) begin
                        state_next = S_CHECK;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_done) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                // remaining is decremented on this same edge
                state_next = (remaining_reg == 16'd1) ? S_CHECK : S_DATA;
            end
            S_CHECK: begin
                if (word_done) begin
                    state_next = (word == acc_reg) ? S_DONE : S_ERR;
                end
            end
            S_DONE:  state_next = S_DONE;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_ORIGIN;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic (Moore)
    // -----------------------------------------------------------------------
    always_comb begin
        rx_ready   = 1'b0;
        ldMARSpcIn = 1'b0;
        cpu_hold   = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state_reg)
            S_ORIGIN, S_COUNT, S_DATA, S_CHECK: rx_ready = 1'b1;
            S_WRITE: ldMARSpcIn = 1'b1;
            S_DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            S_ERR:   error = 1'b1;
            default: rx_ready = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_reg     <= 1'b0;
            hi_reg        <= 8'h00;
            addr_reg      <= 16'h0000;
            data_reg      <= 16'h0000;
            remaining_reg <= 16'h0000;
            acc_reg       <= 16'h0000;
            mar_reg       <= 16'h0000;
            mdr_reg       <= 16'h0000;
        end else begin
            if (accept) begin
                phase_reg <= ~phase_reg;
                if (!phase_reg) begin
                    hi_reg <= rx_data;
                end
            end

            if (word_done) begin
                case (state_reg)
                    S_ORIGIN: addr_reg <= word;
                    S_COUNT: begin
                        remaining_reg <= word;
                        acc_reg       <= 16'h0000;
                    end
                    S_DATA: begin
                        data_reg <= word;
                        acc_reg  <= acc_reg ^ word;
                        // Stage the write so the memory port shows the
                        // address/data for exactly the S_WRITE cycle and
                        // then simply holds them.
                        mar_reg  <= addr_reg;
                        mdr_reg  <= word;
                    end
                    default: ;
                endcase
            end

            if (state_reg == S_WRITE) begin
                addr_reg      <= addr_reg + 16'd1;
                remaining_reg <= remaining_reg - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lc3_loader.sv
// ---------------------------------------------------------------------------
// tb_lc3_loader
//
// Directed image loads. Expected memory writes are queued before each image
// is streamed in; an independent monitor pops and compares on every write
// strobe. Status outputs are checked after each image completes.
// ---------------------------------------------------------------------------
module tb_lc3_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [15:0] MARSpcIn;
    logic [15:0] MDRSpcIn;
    logic        ldMARSpcIn;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];   // {addr, data}
    logic        prev_ld = 1'b0;

    lc3_loader #(.MAX_WORDS(16'hFE00)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .MARSpcIn   (MARSpcIn),
        .MDRSpcIn   (MDRSpcIn),
        .ldMARSpcIn (ldMARSpcIn),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Monitor: compare every write strobe against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (ldMARSpcIn) begin
                logic [31:0] e;
                if (prev_ld) begin
                    tests++;
                    fails++;
                    $display("FAIL strobe_width: strobe high for consecutive cycles at addr %h", MARSpcIn);
                end
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %h data %h, expected no write", MARSpcIn, MDRSpcIn);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] write addr=%h data=%h (expected %h/%h)", MARSpcIn, MDRSpcIn, e[31:16], e[15:0]);
                    check("write_addr", {16'h0, MARSpcIn}, {16'h0, e[31:16]});
                    check("write_data", {16'h0, MDRSpcIn}, {16'h0, e[15:0]});
                end
            end
            prev_ld = ldMARSpcIn;
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!rx_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: byte %h got no rx_ready, expected acceptance", b);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mar"},   {16'h0, MARSpcIn}, 32'h0);
        check({tag, "_mdr"},   {16'h0, MDRSpcIn}, 32'h0);
        check({tag, "_ld"},    {31'h0, ldMARSpcIn}, 32'h0);
        check({tag, "_done"},  {31'h0, done}, 32'h0);
        check({tag, "_error"}, {31'h0, error}, 32'h0);
        check({tag, "_hold"},  {31'h0, cpu_hold}, 32'h1);
        check({tag, "_ready"}, {31'h0, rx_ready}, 32'h1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic h, input logic r);
        repeat (2) @(negedge clk);
        $display("[TB] %s status done=%b error=%b hold=%b ready=%b", tag, done, error, cpu_hold, rx_ready);
        check({tag, "_done"},  {31'h0, done}, {31'h0, d});
        check({tag, "_error"}, {31'h0, error}, {31'h0, e});
        check({tag, "_hold"},  {31'h0, cpu_hold}, {31'h0, h});
        check({tag, "_ready"}, {31'h0, rx_ready}, {31'h0, r});
        check({tag, "_pending"}, exp_q.size(), 32'h0);
    endtask

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b1;

        // Basic two-word image
        exp_q.push_back({16'h3000, 16'h1234});
        exp_q.push_back({16'h3001, 16'hABCD});
        send_word(16'h3000, 0);
        send_word(16'h0002, 0);
        send_word(16'h1234, 0);
        send_word(16'hABCD, 0);
        send_word(16'hB9F9, 0);
        check_status("good", 1'b1, 1'b0, 1'b0, 1'b0);

        // Bytes offered after completion are ignored
        @(negedge clk);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (4) @(negedge clk);
        rx_valid = 1'b0;
        check_status("after_done", 1'b1, 1'b0, 1'b0, 1'b0);

        // Bad checksum
        do_reset("rst1");
        exp_q.push_back({16'h3000, 16'h1234});
        exp_q.push_back({16'h3001, 16'hABCD});
        send_word(16'h3000, 0);
        send_word(16'h0002, 0);
        send_word(16'h1234, 0);
        send_word(16'hABCD, 0);
        send_word(16'h0000, 0);
        check_status("badsum", 1'b0, 1'b1, 1'b1, 1'b0);

        // Address wrap, with idle gaps between bytes
        do_reset("rst2");
        exp_q.push_back({16'hFFFF, 16'h0001});
        exp_q.push_back({16'h0000, 16'h0002});
        send_word(16'hFFFF, 3);
        send_word(16'h0002, 1);
        send_word(16'h0001, 5);
        send_word(16'h0002, 2);
        send_word(16'h0003, 4);
        check_status("wrap", 1'b1, 1'b0, 1'b0, 1'b0);

        // Empty image
        do_reset("rst3");
        send_word(16'h4000, 0);
        send_word(16'h0000, 0);
        send_word(16'h0000, 0);
        check_status("empty", 1'b1, 1'b0, 1'b0, 1'b0);

        // Oversized count
        do_reset("rst4");
        send_word(16'h0000, 0);
        send_word(16'hFFFF, 0);
        @(negedge clk);
        check("bigcount_error_now", {31'h0, error}, 32'h1);
        check("bigcount_ready_now", {31'h0, rx_ready}, 32'h0);
        check_status("bigcount", 1'b0, 1'b1, 1'b1, 1'b0);

        // Reset between the two bytes of the second payload word
        do_reset("rst5");
        exp_q.push_back({16'h3000, 16'h1234});
        send_word(16'h3000, 0);
        send_word(16'h0002, 0);
        send_word(16'h1234, 0);
        send_byte(8'hAB, 0);
        do_reset("midload");
        repeat (3) @(negedge clk);
        check("midload_pending", exp_q.size(), 32'h0);
        check("midload_ready", {31'h0, rx_ready}, 32'h1);
        exp_q.push_back({16'h3000, 16'h1234});
        exp_q.push_back({16'h3001, 16'hABCD});
        send_word(16'h3000, 0);
        send_word(16'h0002, 0);
        send_word(16'h1234, 0);
        send_word(16'hABCD, 0);
        send_word(16'hB9F9, 0);
        check_status("reload", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
